// File: rtl/zpaq_burst_reader.sv
// AXI4 read master that bursts a DDR byte region into a word FIFO and unpacks it
// little-endian onto an 8-bit stream with tlast on the final byte.
module zpaq_burst_reader #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW_BYTES  = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned ARUSER_W  = 2,
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned FIFO_LENW = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [31:0]           byte_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_W-1:0]       arid,
  output logic [AW-1:0]         araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [ARUSER_W-1:0]   aruser,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [8*DW_BYTES-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int unsigned DW    = 8 * DW_BYTES;
  localparam int unsigned LW    = $clog2(DW_BYTES);
  localparam int unsigned DEPTH = 1 << FIFO_LENW;
  localparam int unsigned CW    = FIFO_LENW + 1;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       words_left_q, words_out_q, words_in, burst;
  logic [LW-1:0]     tail_q, lane_q, last_lane;
  logic [AW-1:0]     araddr_q;
  logic              err_q;
  logic [CW-1:0]     resv_q, wptr_q, rptr_q, count, free;
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_data_q;
  logic              rd_valid_q;
  logic [7:0]        m_tdata_q;
  logic              m_tvalid_q, m_tlast_q;
  logic              empty, full, space_ok, ar_hs, r_hs, fifo_we, fifo_re;
  logic              last_word, out_load, word_done;

  assign words_in = (byte_len >> LW) + {31'b0, |byte_len[LW-1:0]};
  assign burst    = (words_left_q < 32'(BURST_LEN)) ? words_left_q : 32'(BURST_LEN);

  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[CW-1] != rptr_q[CW-1]) && (wptr_q[CW-2:0] == rptr_q[CW-2:0]);
  // Space not yet written but already promised to the outstanding burst counts as used.
  assign free     = CW'(DEPTH) - count - resv_q;
  assign space_ok = 32'(free) >= burst;

  assign arvalid  = (state_q == StAddr) && space_ok;
  assign ar_hs    = arvalid && arready;
  assign rready   = (state_q == StData);
  assign r_hs     = rvalid && rready;
  assign fifo_we  = r_hs && !full;

  assign last_word = (words_out_q == 32'd1);
  assign last_lane = (last_word && tail_q != '0) ? tail_q - 1'b1 : LW'(DW_BYTES - 1);
  assign out_load  = rd_valid_q && (!m_tvalid_q || m_tready);
  assign word_done = out_load && (lane_q == last_lane);
  // Refill the read register in the same cycle its last lane leaves, so words flow back to back.
  assign fifo_re   = !empty && (!rd_valid_q || word_done);

  assign busy     = (state_q == StAddr) || (state_q == StData) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign err      = err_q;
  assign arid     = '0;
  assign araddr   = araddr_q;
  assign arlen    = (state_q == StAddr) ? 8'(burst - 32'd1) : 8'd0;
  assign arsize   = 3'(LW);
  assign arburst  = 2'b01;
  assign arcache  = 4'b0011;
  assign arprot   = 3'b000;
  assign aruser   = '0;
  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (byte_len == 32'd0) ? StDone : StAddr;
      StAddr:  if (ar_hs) state_d = StData;
      StData:  if (r_hs && rlast) state_d = (words_left_q != 32'd0) ? StAddr : StDrain;
      StDrain: if (m_tvalid_q && m_tready && m_tlast_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_we) mem[wptr_q[CW-2:0]] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      words_left_q <= '0;
      words_out_q  <= '0;
      tail_q       <= '0;
      araddr_q     <= '0;
      err_q        <= 1'b0;
      resv_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      lane_q       <= '0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        words_left_q <= words_in;
        words_out_q  <= words_in;
        tail_q       <= byte_len[LW-1:0];
        araddr_q     <= base_addr;
        err_q        <= 1'b0;
      end
      if (ar_hs) begin
        araddr_q     <= araddr_q + AW'(burst * DW_BYTES);
        words_left_q <= words_left_q - burst;
      end
      if (ar_hs)                          resv_q <= burst[CW-1:0];
      else if (r_hs && rlast)             resv_q <= '0;
      else if (fifo_we && resv_q != '0)   resv_q <= resv_q - 1'b1;
      if (r_hs && rresp != 2'b00) err_q <= 1'b1;
      if (fifo_we) wptr_q <= wptr_q + 1'b1;
      if (fifo_re) begin
        rptr_q     <= rptr_q + 1'b1;
        rd_data_q  <= mem[rptr_q[CW-2:0]];
        rd_valid_q <= 1'b1;
      end else if (word_done) begin
        rd_valid_q <= 1'b0;
      end
      if (out_load) begin
        m_tdata_q  <= rd_data_q[{lane_q, 3'b000} +: 8];
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= word_done && last_word;
        lane_q     <= word_done ? '0 : lane_q + 1'b1;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end
      if (word_done) words_out_q <= words_out_q - 32'd1;
    end
  end

endmodule
